// File: rtl/aes_round_key_store_if.sv
// Bus between the AES-128 round-key store and its consumer (decrypt core or bench).
// The master loads the cipher key and indexes round keys; the slave expands and serves them.
interface aes_round_key_store_if #(
   parameter int unsigned KW = 128
);
   logic          key_load;
   logic [KW-1:0] key_in;
   logic          key_busy;
   logic          key_ready;
   logic [3:0]    rd_round;
   logic [KW-1:0] rd_key;
   logic          rd_valid;

   modport master (
      output key_load, key_in, rd_round,
      input  key_busy, key_ready, rd_key, rd_valid
   );

   modport slave (
      input  key_load, key_in, rd_round,
      output key_busy, key_ready, rd_key, rd_valid
   );
endinterface

// File: rtl/aes_round_key_store.sv
// Expands an AES-128 cipher key into rk0..rk10, one round key per clock, and
// serves any entry through a zero-latency combinational read port.
module aes_round_key_store #(
   parameter int unsigned NR = 10,
   parameter int unsigned KW = 128
) (
   input logic                 clk,
   input logic                 rst_n,
   aes_round_key_store_if.slave bus
);

   localparam logic [3:0] LastRound = 4'(NR);

   // Forward S-box, entry 0 in the most significant byte.
   localparam logic [2047:0] SboxTbl = {
      128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
      128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
      128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
      128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
      128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
      128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
      128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
      128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
   };

   function automatic logic [7:0] sbox(input logic [7:0] b);
      return SboxTbl[{~b, 3'b000} +: 8];
   endfunction

   typedef enum logic [1:0] {StIdle, StExpand, StReady} state_e;

   state_e        state_q, state_d;
   logic [KW-1:0] rk_q [NR+1];
   logic [KW-1:0] rk_d [NR+1];
   logic [3:0]    cnt_q, cnt_d;
   logic [7:0]    rcon_q, rcon_d;
   logic          busy_q, busy_d;
   logic          ready_q, ready_d;

   logic [KW-1:0] prev_key, next_key;
   logic [31:0]   w0, w1, w2, w3, rot_w, sub_w, w4, w5, w6, w7;

   always_comb begin
      prev_key = '0;
      if (cnt_q != 4'd0 && cnt_q <= LastRound) prev_key = rk_q[cnt_q - 4'd1];
   end

   assign w0    = prev_key[127:96];
   assign w1    = prev_key[95:64];
   assign w2    = prev_key[63:32];
   assign w3    = prev_key[31:0];
   assign rot_w = {w3[23:0], w3[31:24]};
   assign sub_w = {sbox(rot_w[31:24]), sbox(rot_w[23:16]), sbox(rot_w[15:8]), sbox(rot_w[7:0])};
   assign w4    = w0 ^ sub_w ^ {rcon_q, 24'h0};
   assign w5    = w1 ^ w4;
   assign w6    = w2 ^ w5;
   assign w7    = w3 ^ w6;
   assign next_key = {w4, w5, w6, w7};

   always_comb begin
      state_d = state_q;
      rk_d    = rk_q;
      cnt_d   = cnt_q;
      rcon_d  = rcon_q;
      busy_d  = busy_q;
      ready_d = ready_q;
      unique case (state_q)
         StIdle, StReady: begin
            if (bus.key_load) begin
               rk_d[0] = bus.key_in;
               cnt_d   = 4'd1;
               rcon_d  = 8'h01;
               busy_d  = 1'b1;
               ready_d = 1'b0;
               state_d = StExpand;
            end
         end
         StExpand: begin
            // key_load is deliberately ignored here; the running expansion always completes.
            if (cnt_q <= LastRound) rk_d[cnt_q] = next_key;
            cnt_d  = cnt_q + 4'd1;
            rcon_d = {rcon_q[6:0], 1'b0} ^ (rcon_q[7] ? 8'h1b : 8'h00);
            if (cnt_q >= LastRound) begin
               busy_d  = 1'b0;
               ready_d = 1'b1;
               state_d = StReady;
            end
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= StIdle;
         rk_q    <= '{default: '0};
         cnt_q   <= 4'd0;
         rcon_q  <= 8'h00;
         busy_q  <= 1'b0;
         ready_q <= 1'b0;
      end else begin
         state_q <= state_d;
         rk_q    <= rk_d;
         cnt_q   <= cnt_d;
         rcon_q  <= rcon_d;
         busy_q  <= busy_d;
         ready_q <= ready_d;
      end
   end

   assign bus.key_busy  = busy_q;
   assign bus.key_ready = ready_q;
   assign bus.rd_key    = (bus.rd_round <= LastRound) ? rk_q[bus.rd_round] : '0;
   assign bus.rd_valid  = ready_q && (bus.rd_round <= LastRound);

endmodule

// File: tb/tb_aes_round_key_store.sv
// Bench for aes_round_key_store: a FIPS-197 key-schedule model checked every cycle,
// directed vectors, and a behavioural inverse cipher that reads keys from the store.
module tb_aes_round_key_store;

   typedef logic [127:0] key_arr_t [0:10];

   localparam logic [127:0] K1 = 128'h2b7e151628aed2a6abf7158809cf4f3c;
   localparam logic [127:0] K2 = 128'h000102030405060708090a0b0c0d0e0f;
   localparam logic [127:0] CT = 128'h3925841d02dc09fbdc118597196a0b32;
   localparam logic [127:0] PT = 128'h3243f6a8885a308d313198a2e0370734;

   logic clk = 1'b0;
   logic rst_n;
   int   total = 0;
   int   bad = 0;

   aes_round_key_store_if #(.KW(128)) bus ();

   aes_round_key_store #(.NR(10), .KW(128)) dut (
      .clk  (clk),
      .rst_n(rst_n),
      .bus  (bus)
   );

   always #5 clk = ~clk;

   logic [7:0] sb  [256];
   logic [7:0] isb [256];

   task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
      logic [7:0] p = 8'h00;
      logic [7:0] aa = a;
      logic [7:0] bb = b;
      for (int i = 0; i < 8; i++) begin
         if (bb[0]) p ^= aa;
         aa = {aa[6:0], 1'b0} ^ (aa[7] ? 8'h1b : 8'h00);
         bb = bb >> 1;
      end
      return p;
   endfunction

   // S-box from its algebraic definition: GF(2^8) inverse followed by the affine map.
   task automatic build_sbox();
      logic [7:0] inv, s;
      for (int x = 0; x < 256; x++) begin
         inv = 8'h00;
         for (int y = 1; y < 256; y++) if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
         s = inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^ {inv[4:0], inv[7:5]}
             ^ {inv[3:0], inv[7:4]} ^ 8'h63;
         sb[x]  = s;
         isb[s] = 8'(x);
      end
   endtask

   function automatic logic [31:0] sub_word(input logic [31:0] w);
      return {sb[w[31:24]], sb[w[23:16]], sb[w[15:8]], sb[w[7:0]]};
   endfunction

   task automatic expand(input logic [127:0] k, output key_arr_t rk);
      logic [31:0] w [44];
      logic [31:0] t;
      logic [7:0]  rc = 8'h01;
      for (int i = 0; i < 4; i++) w[i] = k[127-32*i -: 32];
      for (int i = 4; i < 44; i++) begin
         t = w[i-1];
         if (i % 4 == 0) begin
            t  = sub_word({t[23:0], t[31:24]}) ^ {rc, 24'h0};
            rc = {rc[6:0], 1'b0} ^ (rc[7] ? 8'h1b : 8'h00);
         end
         w[i] = w[i-4] ^ t;
      end
      for (int r = 0; r < 11; r++) rk[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
   endtask

   // Model: m_k counts round keys written for the current key (0 idle, 11 complete).
   key_arr_t m_keys, m_exp;
   int       m_k = 0;

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         m_k = 0;
         for (int i = 0; i < 11; i++) m_keys[i] = '0;
      end else if ((m_k == 0 || m_k == 11) && bus.key_load) begin
         expand(bus.key_in, m_exp);
         m_keys[0] = bus.key_in;
         m_k = 1;
      end else if (m_k >= 1 && m_k <= 10) begin
         m_keys[m_k] = m_exp[m_k];
         m_k++;
      end
   end

   always @(negedge clk) begin
      if (rst_n === 1'b1) begin
         chk("cyc_busy", 128'(bus.key_busy), 128'(m_k >= 1 && m_k <= 10));
         chk("cyc_ready", 128'(bus.key_ready), 128'(m_k == 11));
         chk("cyc_rd_valid", 128'(bus.rd_valid), 128'(m_k == 11 && bus.rd_round <= 4'd10));
         chk("cyc_rd_key", bus.rd_key, (bus.rd_round <= 4'd10) ? m_keys[bus.rd_round] : '0);
      end
   end

   function automatic logic [127:0] inv_sub_shift(input logic [127:0] s);
      logic [127:0] o;
      for (int c = 0; c < 4; c++)
         for (int r = 0; r < 4; r++)
            o[127-8*(r+4*c) -: 8] = isb[s[127-8*(r+4*((c-r+4)%4)) -: 8]];
      return o;
   endfunction

   function automatic logic [127:0] inv_mix(input logic [127:0] s);
      logic [127:0] o;
      logic [7:0] a0, a1, a2, a3;
      for (int c = 0; c < 4; c++) begin
         a0 = s[127-32*c -: 8];
         a1 = s[119-32*c -: 8];
         a2 = s[111-32*c -: 8];
         a3 = s[103-32*c -: 8];
         o[127-32*c -: 8] = gmul(a0, 8'h0e) ^ gmul(a1, 8'h0b) ^ gmul(a2, 8'h0d) ^ gmul(a3, 8'h09);
         o[119-32*c -: 8] = gmul(a0, 8'h09) ^ gmul(a1, 8'h0e) ^ gmul(a2, 8'h0b) ^ gmul(a3, 8'h0d);
         o[111-32*c -: 8] = gmul(a0, 8'h0d) ^ gmul(a1, 8'h09) ^ gmul(a2, 8'h0e) ^ gmul(a3, 8'h0b);
         o[103-32*c -: 8] = gmul(a0, 8'h0b) ^ gmul(a1, 8'h0d) ^ gmul(a2, 8'h09) ^ gmul(a3, 8'h0e);
      end
      return o;
   endfunction

   // Stand-in decrypt core: walks rd_round 10 down to 0, consuming keys straight from the store.
   task automatic decrypt(input logic [127:0] ct, output logic [127:0] pt, output logic done);
      logic [127:0] s;
      done = 1'b1;
      bus.rd_round = 4'd10;
      #1;
      done &= bus.rd_valid;
      s = ct ^ bus.rd_key;
      for (int r = 9; r >= 0; r--) begin
         s = inv_sub_shift(s);
         bus.rd_round = 4'(r);
         #1;
         done &= bus.rd_valid;
         s = s ^ bus.rd_key;
         if (r != 0) s = inv_mix(s);
      end
      pt = s;
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic do_load(input logic [127:0] k, input bit intrude, output int lat);
      bus.key_in   = k;
      bus.key_load = 1'b1;
      step();
      bus.key_load = 1'b0;
      bus.key_in   = ~k;
      chk("busy_at_load", 128'(bus.key_busy), 128'd1);
      chk("ready_drop_at_load", 128'(bus.key_ready), 128'd0);
      lat = 0;
      while (!bus.key_ready && lat < 20) begin
         if (intrude && lat == 2) begin
            bus.key_in   = K2;
            bus.key_load = 1'b1;
         end
         step();
         bus.key_load = 1'b0;
         lat++;
      end
      chk("load_to_ready_latency", 128'(lat), 128'd10);
   endtask

   task automatic rd_chk(input string nm, input logic [3:0] r, input logic [127:0] exp,
                         input logic exp_valid);
      bus.rd_round = r;
      #1;
      chk(nm, bus.rd_key, exp);
      chk({nm, "_valid"}, 128'(bus.rd_valid), 128'(exp_valid));
   endtask

   task automatic reset_clear_chk();
      chk("rst_busy", 128'(bus.key_busy), 128'd0);
      chk("rst_ready", 128'(bus.key_ready), 128'd0);
      for (int r = 0; r < 16; r++) rd_chk("rst_rd_key", 4'(r), '0, 1'b0);
   endtask

   initial begin
      int           lat;
      logic [127:0] pt;
      logic         done;
      rst_n        = 1'b0;
      bus.key_load = 1'b0;
      bus.key_in   = '0;
      bus.rd_round = 4'd0;
      build_sbox();
      #12;
      reset_clear_chk();
      @(negedge clk);
      rst_n = 1'b1;
      step();

      // First expansion with an ignored key_load on EXPAND cycle 3.
      do_load(K1, 1'b1, lat);
      rd_chk("rk0_k1", 4'd0, K1, 1'b1);
      rd_chk("rk1_k1", 4'd1, 128'ha0fafe1788542cb123a339392a6c7605, 1'b1);
      rd_chk("rk10_k1", 4'd10, 128'hd014f9a8c9ee2589e13f0cc8b6630ca6, 1'b1);
      rd_chk("rd_round_11", 4'd11, '0, 1'b0);
      rd_chk("rd_round_15", 4'd15, '0, 1'b0);

      decrypt(CT, pt, done);
      chk("decrypt_pt", pt, PT);
      chk("decrypt_done", 128'(done), 128'd1);

      // Reload while READY.
      step();
      do_load(K2, 1'b0, lat);
      rd_chk("rk10_k2", 4'd10, 128'h13111d7fe3944a17f307a78b4d2b30c5, 1'b1);
      rd_chk("rk0_k2", 4'd0, K2, 1'b1);

      // Asynchronous reset mid-expansion, then reload.
      bus.rd_round = 4'd3;
      bus.key_in   = K1;
      bus.key_load = 1'b1;
      step();
      bus.key_load = 1'b0;
      repeat (4) @(posedge clk);
      #3;
      rst_n = 1'b0;
      #1;
      reset_clear_chk();
      @(negedge clk);
      rst_n = 1'b1;
      step();
      do_load(K1, 1'b0, lat);
      rd_chk("rk10_after_rst", 4'd10, 128'hd014f9a8c9ee2589e13f0cc8b6630ca6, 1'b1);
      decrypt(CT, pt, done);
      chk("decrypt_pt_after_rst", pt, PT);
      chk("decrypt_done_after_rst", 128'(done), 128'd1);

      step();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/aes_round_key_store.md
Name: aes_round_key_store

Overview:
- Upstream neighbour of the AES decrypt core.
- Expands a 128-bit cipher key once into all 11 round keys (rk0..rk10, FIPS-197 schedule) and holds them in a register file.
- The decrypt core can then index any round key, in any order (typically 10 down to 0), with zero-cycle read latency.
- Removes the need to re-run the key expander per round during decryption.

Parameters:
- NR, 10, number of AES rounds. Fixed for AES-128; array depth is NR+1.
- KW, 128, key and round-key width in bits.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- key_load  input  1  single-cycle request to latch key_in and start expansion
- key_in  input  KW  cipher key, sampled on the key_load edge
- key_busy  output  1  expansion in progress
- key_ready  output  1  all 11 round keys valid
- rd_round  input  4  round index to read (0..10)
- rd_key  output  KW  round key for rd_round (combinational read of the array)
- rd_valid  output  1  key_ready AND rd_round<=10

Behaviour:
- Clock and reset: one clock, clk. Reset is asynchronous, active-low, on rst_n.
- Reset values:
  - FSM to IDLE.
  - All rk entries, round counter, rcon register, key_busy and key_ready to 0.
  - rd_key reads 0; rd_valid is 0.
- FSM states IDLE, EXPAND, READY.
- IDLE:
  - key_load=1 at edge N: rk0<=key_in, cnt<=1, rcon<=8'h01, go to EXPAND.
  - key_busy is 1 from N.
- EXPAND, at each edge while cnt<=10:
  - rk[cnt] is computed from rk[cnt-1]:
    - w4 = w0 ^ SubWord(RotWord(w3)) ^ {rcon,24'h0}
    - w5 = w1^w4, w6 = w2^w5, w7 = w3^w6
  - Word w0 is bits [127:96].
  - Then cnt++ and rcon<=xtime(rcon): shift left 1, XOR 8'h1b if bit7 was set. Sequence is 01,02,04,08,10,20,40,80,1b,36.
- Edge N+10:
  - rk10 is written.
  - FSM goes to READY, key_busy<=0, key_ready<=1.
  - Latency from key_load to key_ready visible is 10 cycles.
- The S-box is an internal 256-entry combinational table. Four instances are used in parallel, one per byte of the rotated word.
- READY:
  - Holds the array.
  - key_load=1: same action as in IDLE. key_ready drops at that edge and rises again 10 cycles later.
  - Stale keys must never read as valid.
- key_load during EXPAND is ignored. The current expansion completes unchanged.
- Read port:
  - rd_key = rk[rd_round] when rd_round<=10, else 0.
  - The read is purely combinational and independent of state.
  - Entries already written during EXPAND are visible, but rd_valid=0 until READY.
- If rd_round changes in the same cycle that an entry is written, rd_key shows the old array contents until that edge. No bypass.
- Reset mid-EXPAND: immediate return to IDLE. All state is cleared, including partial keys.
- key_in changing outside the key_load edge has no effect.

Test Plan:
- Reset check: assert rst_n=0 asynchronously mid-cycle -> key_busy=0, key_ready=0, rd_key=0 for every rd_round, with no clock edge required.
- Expansion latency: key_load one cycle with key_in=2b7e151628aed2a6abf7158809cf4f3c -> key_busy high 10 cycles, key_ready high exactly 10 edges after load.
- Key values, all rd_valid=1:
  - rd_round=0 -> 2b7e151628aed2a6abf7158809cf4f3c
  - rd_round=1 -> a0fafe1788542cb123a339392a6c7605
  - rd_round=10 -> d014f9a8c9ee2589e13f0cc8b6630ca6
- Bounds: rd_round=11 and rd_round=15 -> rd_key=0, rd_valid=0. Also pulse key_load at cycle 3 of EXPAND with a different key -> ignored, and rk10 still equals d014f9a8….
- Reload in READY: load key 000102030405060708090a0b0c0d0e0f -> key_ready drops at the load edge and rises 10 cycles later. rd_round=10 then reads 13111d7fe3944a17f307a78b4d2b30c5.
- Integration with decrypt core:
  - Drive rd_round from the core's round output.
  - Ciphertext 3925841d02dc09fbdc118597196a0b32 with key 2b7e1516… -> plaintext 3243f6a8885a308d313198a2e0370734, done asserted.
  - Additionally, asserting rst_n=0 mid-expansion then reloading gives identical results.
